// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the TX driver and the serial transmitter.
//   XMitGo  - driver -> transmitter, request to send TxData
//   TxData  - driver -> transmitter, byte to send (sampled on the accepting edge)
//   TxEmpty - transmitter -> driver, idle and able to accept a byte
interface uart_tx_if;
    logic       XMitGo;
    logic [7:0] TxData;
    logic       TxEmpty;

    modport master (output XMitGo, output TxData, input TxEmpty);
    modport slave  (input XMitGo, input TxData, output TxEmpty);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 asynchronous serial transmitter.
//   Clock - system clock, rising-edge active
//   Reset - asynchronous, active-low reset
//   drv   - driver handshake (XMitGo/TxData in, TxEmpty out)
//   Tx    - registered serial line, idles high
// One byte is accepted per XMitGo while idle; the frame is start bit, eight
// data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8
) (
    input  logic      Clock,
    input  logic      Reset,
    uart_tx_if.slave  drv,
    output logic      Tx
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             empty_q, empty_d;
    logic             cnt_done;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cnt_done = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (drv.XMitGo) begin
                    shift_d = drv.TxData;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Line level and ready flag are derived from the next state so both
        // come straight out of flops, aligned with the state register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        empty_d = (state_d == IDLE);
    end

    assign Tx          = tx_q;
    assign drv.TxEmpty = empty_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a byte scoreboard.
// Two instances: N=4 for cycle-accurate frame checks, N=1302 for the default rate.
module tb_uart_tx;

    localparam int N  = 4;
    localparam int ND = 1302;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic tx4, txd;

    uart_tx_if if4 ();
    uart_tx_if ifd ();

    uart_tx #(.CLKS_PER_BIT(N)) dut4 (
        .Clock (Clock),
        .Reset (Reset),
        .drv   (if4.slave),
        .Tx    (tx4)
    );

    uart_tx #(.CLKS_PER_BIT(ND)) dutd (
        .Clock (Clock),
        .Reset (Reset),
        .drv   (ifd.slave),
        .Tx    (txd)
    );

    always #5 Clock = ~Clock;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_start = 0;
    logic [7:0] sb[$];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit s);
        return s ? txd : tx4;
    endfunction

    function automatic logic empt(input bit s);
        return s ? ifd.TxEmpty : if4.TxEmpty;
    endfunction

    task automatic set_go(input bit s, input logic g, input logic [7:0] d);
        if (s) begin
            ifd.XMitGo = g;
            ifd.TxData = d;
        end else begin
            if4.XMitGo = g;
            if4.TxData = d;
        end
    endtask

    // Present a byte, let the accepting edge pass, then scramble TxData.
    task automatic send(input bit s, input logic [7:0] b, input bit hold);
        set_go(s, 1'b1, b);
        sb.push_back(b);
        @(negedge Clock);
        set_go(s, hold, 8'($urandom));
    endtask

    // Follow one frame cycle by cycle from the first start-bit sample.
    task automatic watch(input bit s, input int n, input string tag,
                         input int pulse_at, input int abort_at);
        int         w = 0;
        int         werr = 0;
        int         berr = 0;
        logic [7:0] exp;
        logic [7:0] got = '0;
        logic [9:0] frame;
        bit         aborted = 0;
        while (line(s) !== 1'b0 && w < 3 * n) begin
            @(negedge Clock);
            w++;
        end
        check({tag, " start"}, {31'b0, line(s)}, 32'd0);
        if (line(s) !== 1'b0) return;
        last_start = cyc;
        check({tag, " sb depth"}, sb.size(), 32'd1);
        exp   = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        frame = {1'b1, exp, 1'b0};
        for (int j = 0; j < 10 * n; j++) begin
            if (j == abort_at) begin
                Reset = 1'b0;
                #1;
                check({tag, " rst Tx"}, {31'b0, line(s)}, 32'd1);
                check({tag, " rst empty"}, {31'b0, empt(s)}, 32'd1);
                aborted = 1;
                break;
            end
            if (pulse_at >= 0 && j == pulse_at)     set_go(s, 1'b1, 8'hFF);
            if (pulse_at >= 0 && j == pulse_at + 1) set_go(s, 1'b0, 8'hFF);
            if (line(s) !== frame[j / n]) werr++;
            if (empt(s) !== 1'b0) berr++;
            if (j / n >= 1 && j / n <= 8 && j % n == n / 2) got[j / n - 1] = line(s);
            @(negedge Clock);
        end
        if (aborted) return;
        check({tag, " wave errs"}, werr, 32'd0);
        check({tag, " busy errs"}, berr, 32'd0);
        check({tag, " decode"}, {24'b0, got}, {24'b0, exp});
        check({tag, " stop Tx"}, {31'b0, line(s)}, 32'd1);
        check({tag, " ready"}, {31'b0, empt(s)}, 32'd1);
    endtask

    initial begin
        int err;
        int s1;
        set_go(0, 1'b1, 8'h00);
        set_go(1, 1'b1, 8'h00);
        Reset = 1'b0;

        // Reset held with XMitGo high: line idle, ready, no frame.
        err = 0;
        repeat (5) begin
            @(negedge Clock);
            if (tx4 !== 1'b1 || if4.TxEmpty !== 1'b1 || txd !== 1'b1 || ifd.TxEmpty !== 1'b1) err++;
        end
        check("reset hold", err, 32'd0);
        check("reset Tx", {31'b0, tx4}, 32'd1);
        check("reset empty", {31'b0, if4.TxEmpty}, 32'd1);
        set_go(0, 1'b0, 8'h00);
        set_go(1, 1'b0, 8'h00);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("idle Tx", {31'b0, tx4}, 32'd1);
        check("idle empty", {31'b0, if4.TxEmpty}, 32'd1);

        // Single frame.
        send(0, 8'h41, 0);
        watch(0, N, "f41", -1, -1);

        // Request while busy is ignored.
        repeat (2) @(negedge Clock);
        send(0, 8'h55, 0);
        watch(0, N, "f55", 12, -1);
        err = 0;
        repeat (3 * N) begin
            @(negedge Clock);
            if (tx4 !== 1'b1 || if4.TxEmpty !== 1'b1) err++;
        end
        check("busy no second frame", err, 32'd0);
        check("busy sb empty", sb.size(), 32'd0);

        // Back-to-back with XMitGo held.
        send(0, 8'hA5, 1);
        watch(0, N, "fA5", -1, -1);
        s1 = last_start;
        send(0, 8'h3C, 0);
        watch(0, N, "f3C", -1, -1);
        check("b2b start gap", last_start - s1, 32'd41);

        // Mid-frame reset abandons the frame.
        repeat (2) @(negedge Clock);
        send(0, 8'hF0, 0);
        watch(0, N, "fF0", -1, 17);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        err = 0;
        repeat (2 * N) begin
            @(negedge Clock);
            if (tx4 !== 1'b1 || if4.TxEmpty !== 1'b1) err++;
        end
        check("post reset idle", err, 32'd0);
        send(0, 8'h0F, 0);
        watch(0, N, "f0F", -1, -1);

        // Default rate, loopback decode of 'H'.
        send(1, 8'h48, 0);
        watch(1, ND, "fH", -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
